// File: rtl/memory_stage_pkg.sv
// cpu_pkg: shared widths, limits and FSM
// encoding for the data-memory stage.
package cpu_pkg;

  localparam int DATA_W      = 16;
  localparam int MEM_TIMEOUT = 15;

  typedef enum logic {
    IDLE,
    ACCESS
  } mem_state_t;

endpackage

// File: rtl/memory_stage_if.sv
// memory_stage_if: data-memory request bus
// between the MEM stage and the memory.
interface memory_stage_if #(
  parameter int DATA_W = cpu_pkg::DATA_W
) ();

  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we,
    output mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we,
    input  mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/memory_stage_timer.sv
// mem_access_timer: counts ACCESS cycles that
// pass without an ack and flags the last one.
module mem_access_timer #(
  parameter int LIMIT = cpu_pkg::MEM_TIMEOUT,
  parameter int TW    = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TW-1:0] count;

  // cycles spent waiting, saturating at LIMIT
  always_ff @(posedge clk) begin
    if (rst || clear)
      count <= '0;
    else if (enable && count != TW'(LIMIT))
      count <= count + 1'b1;
  end

  // the current waiting cycle is the LIMIT-th
  assign expired = enable &&
                   (count == TW'(LIMIT - 1));

endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM pipeline stage issuing a
// single outstanding data-memory access.
module memory_stage #(
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int MEM_TIMEOUT = cpu_pkg::MEM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wbs_in,
  input  logic              mm_in,
  input  logic              wm_in,
  input  logic              ni_in,
  input  logic [DATA_W-1:0] ALUresult_in,
  input  logic [DATA_W-1:0] memData_in,
  memory_stage_if.master    bus,
  output logic              stall_out,
  output logic              wbs_out,
  output logic              ni_out,
  output logic [DATA_W-1:0] wbData_out,
  output logic              err_out
);

  import cpu_pkg::*;

  mem_state_t        state;
  mem_state_t        state_nx;
  logic              op_we;
  logic              op_wbs;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              is_mem;
  logic              start;
  logic              expired;
  logic              waiting;

  assign is_mem  = ~ni_in & (mm_in | wm_in);
  assign waiting = (state == ACCESS) &
                   ~bus.mem_ack;

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  mem_access_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (state == IDLE),
    .enable  (waiting),
    .expired (expired)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next state, stall and bus strobes
  always_comb begin
    state_nx    = state;
    stall_out   = 1'b0;
    start       = 1'b0;
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    if (!rst) begin
      unique case (1'b1)
        state == IDLE: begin
          if (is_mem) begin
            start     = 1'b1;
            stall_out = 1'b1;
            state_nx  = ACCESS;
          end
        end
        state == ACCESS: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = op_we;
          if (bus.mem_ack || expired)
            state_nx  = IDLE;
          else
            stall_out = 1'b1;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // capture the request when an access starts;
  // load+store together is taken as a store
  always_ff @(posedge clk) begin
    if (rst) begin
      op_we   <= 1'b0;
      op_wbs  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (start) begin
      op_we   <= wm_in;
      op_wbs  <= wbs_in & ~wm_in;
      addr_q  <= ALUresult_in;
      wdata_q <= memData_in;
    end
  end

  // MEM/WB register; a bubble while waiting
  always_ff @(posedge clk) begin
    if (rst) begin
      wbs_out    <= 1'b0;
      ni_out     <= 1'b1;
      wbData_out <= '0;
      err_out    <= 1'b0;
    end else begin
      err_out <= 1'b0;
      if (state == IDLE && !is_mem) begin
        wbData_out <= ALUresult_in;
        wbs_out    <= wbs_in & ~ni_in;
        ni_out     <= ni_in;
      end else if (state == IDLE) begin
        wbs_out <= 1'b0;
        ni_out  <= 1'b1;
      end else if (bus.mem_ack) begin
        wbData_out <= op_we ? addr_q
                            : bus.mem_rdata;
        wbs_out    <= op_wbs;
        ni_out     <= 1'b0;
      end else begin
        wbs_out <= 1'b0;
        ni_out  <= 1'b1;
        err_out <= expired;
      end
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: directed and random
// instructions against a transaction model.
module tb_memory_stage;

  localparam int W   = 16;
  localparam int TMO = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         wbs_in;
  logic         mm_in;
  logic         wm_in;
  logic         ni_in;
  logic [W-1:0] ALUresult_in;
  logic [W-1:0] memData_in;
  logic         stall_out;
  logic         wbs_out;
  logic         ni_out;
  logic [W-1:0] wbData_out;
  logic         err_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memory_stage_if #(.DATA_W(W)) bus ();

  memory_stage #(
    .DATA_W      (W),
    .MEM_TIMEOUT (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wbs_in       (wbs_in),
    .mm_in        (mm_in),
    .wm_in        (wm_in),
    .ni_in        (ni_in),
    .ALUresult_in (ALUresult_in),
    .memData_in   (memData_in),
    .bus          (bus),
    .stall_out    (stall_out),
    .wbs_out      (wbs_out),
    .ni_out       (ni_out),
    .wbData_out   (wbData_out),
    .err_out      (err_out)
  );

  task automatic check(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic apply_reset(input string tag);
    rst         = 1'b1;
    bus.mem_ack = 1'b0;
    #1;
    check({tag, ".req_now"},
          W'(bus.mem_req), W'(0));
    check({tag, ".stall_now"},
          W'(stall_out), W'(0));
    @(posedge clk);
    @(negedge clk);
    check({tag, ".wbs"}, W'(wbs_out), W'(0));
    check({tag, ".ni"}, W'(ni_out), W'(1));
    check({tag, ".err"}, W'(err_out), W'(0));
    check({tag, ".wbdata"}, wbData_out, '0);
    check({tag, ".req"}, W'(bus.mem_req), W'(0));
    check({tag, ".stall"}, W'(stall_out), W'(0));
    rst = 1'b0;
  endtask

  // one instruction; memory acks after d
  // waiting ACCESS cycles, stray acks in IDLE
  task automatic do_op(input string tag,
                       input logic wbs,
                       input logic mm,
                       input logic wm,
                       input logic ni,
                       input logic [W-1:0] alu,
                       input logic [W-1:0] wd,
                       input logic [W-1:0] rd,
                       input int d,
                       input logic stray);
    logic is_mem;
    int   exp_acc;
    int   acc;
    int   stalls;
    int   cyc;
    bit   done;
    wbs_in        = wbs;
    mm_in         = mm;
    wm_in         = wm;
    ni_in         = ni;
    ALUresult_in  = alu;
    memData_in    = wd;
    bus.mem_rdata = rd;
    is_mem  = !ni && (mm || wm);
    exp_acc = !is_mem ? 0 :
              (d < TMO ? d + 1 : TMO);
    acc    = 0;
    stalls = 0;
    cyc    = 0;
    done   = 1'b0;
    while (!done && cyc < 64) begin
      bus.mem_ack = bus.mem_req ? (acc == d)
                                : stray;
      #1;
      if (bus.mem_req) begin
        acc++;
        check({tag, ".addr"}, bus.mem_addr, alu);
        check({tag, ".we"},
              W'(bus.mem_we), W'(wm));
        if (wm)
          check({tag, ".wdata"},
                bus.mem_wdata, wd);
        check({tag, ".ni_wait"},
              W'(ni_out), W'(1));
        check({tag, ".wbs_wait"},
              W'(wbs_out), W'(0));
      end
      if (stall_out) stalls++;
      else           done = 1'b1;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    bus.mem_ack = 1'b0;
    check({tag, ".done"}, W'(done), W'(1));
    check({tag, ".stalls"},
          W'(stalls), W'(exp_acc));
    check({tag, ".accesses"},
          W'(acc), W'(exp_acc));
    if (!is_mem) begin
      check({tag, ".wbdata"}, wbData_out, alu);
      check({tag, ".wbs"},
            W'(wbs_out), W'(wbs && !ni));
      check({tag, ".ni"}, W'(ni_out), W'(ni));
      check({tag, ".err"}, W'(err_out), W'(0));
    end else if (d < TMO) begin
      check({tag, ".wbdata"}, wbData_out,
            wm ? alu : rd);
      check({tag, ".wbs"},
            W'(wbs_out), W'(wbs && !wm));
      check({tag, ".ni"}, W'(ni_out), W'(0));
      check({tag, ".err"}, W'(err_out), W'(0));
    end else begin
      check({tag, ".wbs"}, W'(wbs_out), W'(0));
      check({tag, ".ni"}, W'(ni_out), W'(1));
      check({tag, ".err"}, W'(err_out), W'(1));
    end
  endtask

  initial begin
    rst           = 1'b1;
    wbs_in        = 1'b0;
    mm_in         = 1'b0;
    wm_in         = 1'b0;
    ni_in         = 1'b1;
    ALUresult_in  = '0;
    memData_in    = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;

    apply_reset("reset");

    do_op("alu", 1, 0, 0, 0, 16'h1234,
          16'h0000, 16'h0000, 0, 1'b0);
    do_op("load", 1, 1, 0, 0, 16'h0040,
          16'h0000, 16'hABCD, 3, 1'b0);
    do_op("store", 1, 0, 1, 0, 16'h4A81,
          16'h7755, 16'hDEAD, 1, 1'b0);
    do_op("timeout", 1, 1, 0, 0, 16'h0222,
          16'h0000, 16'h5555, 99, 1'b0);
    do_op("after_tmo", 1, 0, 0, 0, 16'h0F0F,
          16'h0000, 16'h0000, 0, 1'b1);
    do_op("ack_at_limit", 1, 1, 0, 0, 16'h0300,
          16'h0000, 16'h6161, TMO - 1, 1'b0);
    do_op("ld_st", 1, 1, 1, 0, 16'h0404,
          16'h9876, 16'h1111, 0, 1'b0);
    do_op("bubble", 1, 0, 1, 1, 16'h0505,
          16'h0000, 16'h0000, 0, 1'b1);

    wbs_in       = 1'b1;
    mm_in        = 1'b1;
    wm_in        = 1'b0;
    ni_in        = 1'b0;
    ALUresult_in = 16'h0100;
    @(posedge clk);
    @(negedge clk);
    check("abort.req1", W'(bus.mem_req), W'(1));
    @(posedge clk);
    @(negedge clk);
    apply_reset("abort");
    do_op("post_rst", 1, 1, 0, 0, 16'h0600,
          16'h0000, 16'h3C3C, 2, 1'b0);

    for (int i = 0; i < 40; i++) begin
      int          kind;
      logic        wbs;
      logic        mm;
      logic        wm;
      logic        ni;
      int          d;
      kind = int'($urandom_range(0, 4));
      wbs  = 1'($urandom);
      mm   = 1'b0;
      wm   = 1'b0;
      ni   = 1'b0;
      unique case (kind)
        0: ;
        1: begin
          ni = 1'b1;
          mm = 1'($urandom);
          wm = 1'($urandom);
        end
        2: mm = 1'b1;
        3: wm = 1'b1;
        default: begin
          mm = 1'b1;
          wm = 1'b1;
        end
      endcase
      d = ($urandom_range(0, 7) == 0) ?
          int'($urandom_range(TMO - 1, 20)) :
          int'($urandom_range(0, 5));
      do_op("rand", wbs, mm, wm, ni,
            W'($urandom), W'($urandom),
            W'($urandom), d, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter DATA_W, default 16: datapath width.
REQ-002 Parameter MEM_TIMEOUT, default 15: maximum ACCESS cycles without mem_ack.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 wbs_in  in  1  writeback-enable from EX/MEM register.
REQ-006 mm_in  in  1  memory read; writeback data comes from memory.
REQ-007 wm_in  in  1  memory write request.
REQ-008 ni_in  in  1  null instruction (bubble) marker.
REQ-009 ALUresult_in  in  DATA_W  ALU result / memory address.
REQ-010 memData_in  in  DATA_W  store data.
REQ-011 mem_req, mem_we  out  1  data-memory request strobe, write-not-read.
REQ-012 mem_addr, mem_wdata  out  DATA_W  memory address, store data.
REQ-013 mem_ack  in  1  memory completion strobe; mem_rdata valid when high.
REQ-014 mem_rdata  in  DATA_W  load data.
REQ-015 stall_out  out  1  freeze upstream stages and EX/MEM register.
REQ-016 wbs_out, ni_out  out  1  registered MEM/WB control.
REQ-017 wbData_out  out  DATA_W  registered writeback data.
REQ-018 err_out  out  1  one-cycle pulse on access timeout.

Function
REQ-019 FSM SHALL have exactly two states: IDLE, ACCESS.
REQ-020 In IDLE with ni_in=1 or mm_in=wm_in=0: wbData_out<=ALUresult_in, wbs_out<=wbs_in&~ni_in, ni_out<=ni_in; latency one cycle; stall_out=0.
REQ-021 In IDLE with ni_in=0 and (mm_in|wm_in): latch address, store data, op; stall_out=1 combinationally that cycle; next state ACCESS; outputs load bubble (ni_out=1, wbs_out=0).
REQ-022 wm_in=mm_in=1 SHALL be treated as a write; wbs_out forced 0 for that instruction.
REQ-023 In ACCESS: mem_req=1, mem_we=op, mem_addr/mem_wdata from latches, stable until exit.
REQ-024 ACCESS with mem_ack=0: stall_out=1, outputs hold bubble, timer increments.
REQ-025 ACCESS with mem_ack=1: stall_out=0; wbData_out<=mem_rdata for read, latched address for write; wbs_out<=latched wbs (0 for write); ni_out<=0; next IDLE.
REQ-026 Timer reaching MEM_TIMEOUT with mem_ack=0: err_out=1 for one cycle, ni_out<=1, wbs_out<=0, stall_out=0, next IDLE.
REQ-027 mem_ack and timeout in the same cycle: ack wins, err_out stays 0.
REQ-028 mem_ack in IDLE SHALL be ignored.
REQ-029 Timer cleared on every ACCESS entry; width ceil(log2(MEM_TIMEOUT+1)).
REQ-030 Outside ACCESS: mem_req=0, mem_we=0.

Reset
REQ-031 rst=1 at a clock edge: state IDLE, timer 0, wbs_out=0, wbData_out=0, ni_out=1, err_out=0, latches 0.
REQ-032 While rst=1: mem_req=0, stall_out=0.
REQ-033 rst during ACCESS SHALL abort the access; mem_req low from the cycle rst is high; no err_out.

Structure
REQ-034 Shared package cpu_pkg SHALL hold DATA_W, MEM_TIMEOUT, and enum mem_state_t {IDLE, ACCESS}.
REQ-035 One sub-module, mem_access_timer (clear, enable, expired), SHALL implement the timeout counter.

Verification
REQ-036 Non-memory: ALUresult_in=16'h1234, wbs_in=1, mm_in=wm_in=0 -> next cycle wbData_out=1234, wbs_out=1, ni_out=0, stall_out never 1.
REQ-037 Load, ack after 3 cycles, mem_rdata=16'hABCD, addr 16'h0040 -> mem_addr=0040, stall_out high 4 cycles, wbData_out=ABCD, wbs_out=1.
REQ-038 Store addr 16'h4A81, data 16'h7755, ack after 1 cycle -> mem_we=1, mem_wdata=7755, wbs_out=0, err_out=0.
REQ-039 Load with mem_ack held 0 -> err_out pulses after 15 ACCESS cycles, ni_out=1, stall_out released.
REQ-040 rst asserted 2 cycles into a load -> mem_req=0 from the rst cycle, ni_out=1, no err_out; new load afterwards completes normally.
REQ-041 Bubble (ni_in=1, wm_in=1) -> no mem_req, ni_out=1, wbs_out=0.
